// File: rtl/canvas_reader.sv
// Canvas reader: scans a 144x192 pixel region as 12x16 cells of 12x12 px,
// counts drawn pixels per cell and hands each count out over a valid/ready port.
module canvas_reader (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       mem_rd,
    output logic [7:0] mem_x,
    output logic [7:0] mem_y,
    input  logic       mem_q,
    output logic [7:0] cell_data,
    output logic [7:0] cell_index,
    output logic       cell_valid,
    input  logic       cell_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] X_ORIGIN   = 8'd86;
    localparam logic [7:0] Y_ORIGIN   = 8'd36;
    localparam logic [3:0] CELL_LAST  = 4'd11;
    localparam logic [3:0] CX_LAST    = 4'd11;
    localparam logic [7:0] INDEX_LAST = 8'd191;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        OUT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] px;
    logic [3:0] py;
    logic [3:0] cx;
    logic [3:0] cy;
    logic [7:0] idx;
    logic [7:0] acc;
    logic       rd_q;
    logic       last_pix;
    logic       last_cell;
    logic [7:0] x_addr;
    logic [7:0] y_addr;

    assign last_pix  = (px == CELL_LAST) && (py == CELL_LAST);
    assign last_cell = (idx == INDEX_LAST);

    // 12*c is formed as 8*c + 4*c to keep the address path adder-only.
    assign x_addr = X_ORIGIN + {1'b0, cx, 3'b000} + {2'b00, cx, 2'b00} + {4'b0000, px};
    assign y_addr = Y_ORIGIN + {1'b0, cy, 3'b000} + {2'b00, cy, 2'b00} + {4'b0000, py};

    always_comb begin
        state_nxt  = state;
        mem_rd     = 1'b0;
        cell_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                mem_rd = 1'b1;
                if (last_pix) state_nxt = FLUSH;
            end
            FLUSH: begin
                state_nxt = OUT;
            end
            OUT: begin
                cell_valid = 1'b1;
                if (cell_ready) state_nxt = last_cell ? IDLE : SCAN;
            end
            default: state_nxt = IDLE;
        endcase
        mem_x      = mem_rd ? x_addr : '0;
        mem_y      = mem_rd ? y_addr : '0;
        cell_data  = cell_valid ? acc : '0;
        cell_index = cell_valid ? idx : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            px    <= '0;
            py    <= '0;
            cx    <= '0;
            cy    <= '0;
            idx   <= '0;
            acc   <= '0;
            rd_q  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_q  <= mem_rd;
            done  <= 1'b0;
            // Pixel data trails its read by one cycle; the FLUSH cycle picks up the last one.
            if (rd_q) acc <= acc + {7'd0, mem_q};

            case (state)
                IDLE: begin
                    if (start) begin
                        px   <= '0;
                        py   <= '0;
                        cx   <= '0;
                        cy   <= '0;
                        idx  <= '0;
                        acc  <= '0;
                        busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (px == CELL_LAST) begin
                        px <= '0;
                        py <= (py == CELL_LAST) ? 4'd0 : py + 4'd1;
                    end else begin
                        px <= px + 4'd1;
                    end
                end
                OUT: begin
                    if (cell_ready) begin
                        acc <= '0;
                        if (last_cell) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            idx <= idx + 8'd1;
                            if (cx == CX_LAST) begin
                                cx <= '0;
                                cy <= cy + 4'd1;
                            end else begin
                                cx <= cx + 4'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/canvas_reader.md
CANVAS_READER -- requirements
Module: canvas_reader

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; clears all state.
REQ-004 start  input  1  one-cycle request to begin a full canvas scan.
REQ-005 mem_rd  output  1  pixel read strobe to the pixel memory.
REQ-006 mem_x  output  8  pixel column of the read address.
REQ-007 mem_y  output  8  pixel row of the read address.
REQ-008 mem_q  input  1  pixel value (1 = drawn); valid exactly one cycle after the matching mem_rd.
REQ-009 cell_data  output  8  count of drawn pixels in the current cell (0..144).
REQ-010 cell_index  output  8  cell number (0..191).
REQ-011 cell_valid  output  1  cell_data and cell_index are presented.
REQ-012 cell_ready  input  1  consumer accepts the presented cell.
REQ-013 busy  output  1  scan in progress.
REQ-014 done  output  1  one-cycle pulse when the last cell is accepted.

Function
REQ-015 Canvas region SHALL be x 86..229 and y 36..227 (144 x 192 px), tiled into 12 x 16 cells of 12 x 12 px.
REQ-016 Cell (cx, cy) SHALL have cx 0..11 and cy 0..15, with cell_index = cy*12 + cx; cells are processed with cx inner and cy outer.
REQ-017 Within a cell, pixel (px, py) SHALL be read at mem_x = 86 + 12*cx + px and mem_y = 36 + 12*cy + py, with px inner (0..11) and py outer (0..11).
REQ-018 The FSM SHALL have the states IDLE, SCAN, FLUSH and OUT.
REQ-019 IDLE -> SCAN on start: cell counters and the accumulator are cleared and busy is set.
REQ-020 In SCAN, mem_rd SHALL be 1 every cycle for exactly 144 consecutive cycles, one new address per cycle; SCAN -> FLUSH after the 144th read.
REQ-021 Each cycle following a read, mem_q SHALL be added to an 8-bit accumulator; the accumulator cannot overflow because the maximum is 144.
REQ-022 In FLUSH (1 cycle), mem_q for the last read SHALL be added; no read is issued; FLUSH -> OUT.
REQ-023 In OUT, cell_valid SHALL be 1, and cell_data and cell_index SHALL be held stable until cell_ready is 1.
REQ-024 A transfer SHALL occur on any clock edge where cell_valid and cell_ready are both 1.
REQ-025 On a transfer, if cell_index < 191 the block SHALL clear the accumulator, advance the cell and go to SCAN.
REQ-026 On a transfer, if cell_index = 191 the block SHALL go to IDLE, pulse done for 1 cycle and clear busy.
REQ-027 cell_ready SHALL be ignored outside OUT; cell_valid SHALL never be 1 outside OUT.
REQ-028 mem_rd SHALL be 0 outside SCAN, and mem_x and mem_y SHALL be 0 whenever mem_rd is 0.
REQ-029 start SHALL be ignored while busy is 1, with no restart and no counter disturbance.
REQ-030 With cell_ready held at 1, each cell SHALL take exactly 146 cycles (144 SCAN + 1 FLUSH + 1 OUT).
REQ-031 A full scan with cell_ready held at 1 SHALL take 28032 cycles from the start edge to the done pulse.
REQ-032 busy SHALL be 1 from the cycle after start is accepted through the final transfer edge.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE and all counters and the accumulator SHALL be cleared to 0.
REQ-034 After reset, mem_rd, mem_x, mem_y, cell_data, cell_index, cell_valid, busy and done SHALL all be 0.
REQ-035 Reset SHALL take priority over start and over transfers in the same cycle.
REQ-036 Reset mid-scan SHALL abort the scan; the next start SHALL begin again at cell 0, pixel (0,0), with no residual count.

Verification
REQ-037 Blank memory (mem_q always 0), cell_ready = 1, start pulse -> 192 transfers with indices 0..191, all cell_data = 0, done at cycle 28032.
REQ-038 Full memory (mem_q always 1) -> every cell_data = 144; the first read is at (86,36) and the last read is at (229,227).
REQ-039 Single drawn pixel at (127,67) -> cell_index 27 has cell_data = 1; all other cells have cell_data = 0.
REQ-040 cell_ready held at 0 for 10 cycles at cell 0 -> cell_valid stays 1, cell_data and cell_index stay stable, mem_rd stays 0; cell 1 SCAN begins the cycle after ready rises.
REQ-041 start re-pulsed during SCAN of cell 5 -> no effect; indices continue 5, 6, ... to 191.
REQ-042 reset asserted at cell 40 mid-SCAN, then start -> outputs 0 after reset; the first transfer is index 0 with the correct count.
